// File: rtl/alu_cmd_capture_pkg.sv
// Shared constants for the ALU command capture front-end: one-hot op codes,
// button lane indices and the board-clock debounce default.
package alu_cmd_capture_pkg;

    localparam int unsigned DEBOUNCE_DEFAULT = 32'd1000000;
    localparam int unsigned CNT_W_DEFAULT    = 32'd20;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b1000;

    // Lane index equals the op_sel bit the button drives.
    localparam int unsigned BTN_ADD = 32'd0;
    localparam int unsigned BTN_SUB = 32'd1;
    localparam int unsigned BTN_AND = 32'd2;
    localparam int unsigned BTN_XOR = 32'd3;
    localparam int unsigned BTN_NUM = 32'd4;

    // Board wiring puts the lowest pin at the operand MSB.
    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/alu_cmd_capture_btn_debounce.sv
// One button lane: 2-flop synchroniser, debounce counter, stable level and
// a single-cycle pulse on each accepted 0->1 transition.
module btn_debounce
    import alu_cmd_capture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic [1:0]       sync_r;
    logic             stable_r;
    logic             stable_d_r;
    logic [CNT_W-1:0] cnt_r;
    logic             raw_s;

    assign raw_s = sync_r[1];

    // Synchronise, then accept a new level only after it persists long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r     <= 2'b00;
            stable_r   <= 1'b0;
            stable_d_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            sync_r     <= {sync_r[0], btn};
            stable_d_r <= stable_r;
            if (raw_s == stable_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                stable_r <= raw_s;
                cnt_r    <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign level = stable_r;
    assign rise  = stable_r & ~stable_d_r;

endmodule

// File: rtl/alu_cmd_capture.sv
// Front-end for the 4-bit ALU: debounces the op buttons and, on each press,
// latches a one-hot op select plus a snapshot of the switch operands.
module alu_cmd_capture
    import alu_cmd_capture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw_pin,
    input  logic [7:0] dip_pin,
    input  logic       btn_0,
    input  logic       btn_1,
    input  logic       btn_3,
    input  logic       btn_4,
    output logic [3:0] op_sel,
    output logic [3:0] opnd_a,
    output logic [3:0] opnd_b,
    output logic [3:0] opnd_c,
    output logic [3:0] opnd_d,
    output logic       op_valid,
    output logic [3:0] btn_state
);

    logic [BTN_NUM-1:0] btn_raw_s;
    logic [BTN_NUM-1:0] level_s;
    logic [BTN_NUM-1:0] rise_s;
    logic [3:0]         sel_s;
    logic [7:0]         sw_meta_r;
    logic [7:0]         sw_sync_r;
    logic [7:0]         dip_meta_r;
    logic [7:0]         dip_sync_r;

    assign btn_raw_s = {btn_0, btn_3, btn_1, btn_4};

    for (genvar i = 0; i < BTN_NUM; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_raw_s[i]),
            .level(level_s[i]),
            .rise (rise_s[i])
        );
    end

    assign btn_state = level_s;

    // Fixed priority when several presses are accepted in the same cycle.
    always_comb begin
        sel_s = 4'b0000;
        if (rise_s[BTN_XOR]) begin
            sel_s = OP_XOR;
        end else if (rise_s[BTN_AND]) begin
            sel_s = OP_AND;
        end else if (rise_s[BTN_SUB]) begin
            sel_s = OP_SUB;
        end else if (rise_s[BTN_ADD]) begin
            sel_s = OP_ADD;
        end else begin
            sel_s = 4'b0000;
        end
    end

    // Switch synchronisers and the press-triggered op/operand snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_r  <= 8'h00;
            sw_sync_r  <= 8'h00;
            dip_meta_r <= 8'h00;
            dip_sync_r <= 8'h00;
            op_sel     <= 4'b0000;
            opnd_a     <= 4'b0000;
            opnd_b     <= 4'b0000;
            opnd_c     <= 4'b0000;
            opnd_d     <= 4'b0000;
            op_valid   <= 1'b0;
        end else begin
            sw_meta_r  <= sw_pin;
            sw_sync_r  <= sw_meta_r;
            dip_meta_r <= dip_pin;
            dip_sync_r <= dip_meta_r;
            if (|rise_s) begin
                op_sel   <= sel_s;
                opnd_a   <= rev4(sw_sync_r[3:0]);
                opnd_b   <= rev4(sw_sync_r[7:4]);
                opnd_c   <= rev4(dip_sync_r[3:0]);
                opnd_d   <= rev4(dip_sync_r[7:4]);
                op_valid <= 1'b1;
            end else begin
                op_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_capture.sv
// Self-checking bench for alu_cmd_capture with a short debounce window:
// a sample-history model checked every cycle plus directed literal checks.
module tb_alu_cmd_capture;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw_pin = 8'h00;
    logic [7:0] dip_pin = 8'h00;
    logic       btn_0 = 1'b0, btn_1 = 1'b0, btn_3 = 1'b0, btn_4 = 1'b0;
    logic [3:0] op_sel, opnd_a, opnd_b, opnd_c, opnd_d, btn_state;
    logic       op_valid;

    int n_checks = 0;
    int n_fail = 0;
    int pulse_cnt = 0;

    alu_cmd_capture #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .sw_pin(sw_pin), .dip_pin(dip_pin),
        .btn_0(btn_0), .btn_1(btn_1), .btn_3(btn_3), .btn_4(btn_4),
        .op_sel(op_sel), .opnd_a(opnd_a), .opnd_b(opnd_b), .opnd_c(opnd_c),
        .opnd_d(opnd_d), .op_valid(op_valid), .btn_state(btn_state)
    );

    always #5 clk = ~clk;

    // Model: histories of the pin values seen at each clock edge (index 0 newest).
    // Lanes ordered {XOR, AND, SUB, ADD}, the same order as op_sel and btn_state.
    logic [3:0] m_bh [0:15];
    logic [7:0] m_sw [0:15];
    logic [7:0] m_dp [0:15];
    logic [3:0] m_stable = 4'b0000;
    logic [3:0] m_rise = 4'b0000;
    logic [3:0] e_op = 4'b0000, e_a = 4'b0000, e_b = 4'b0000, e_c = 4'b0000, e_d = 4'b0000;
    logic       e_valid = 1'b0;

    function automatic logic [3:0] bitrev(input logic [3:0] v);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[3-i] = v[i];
        return r;
    endfunction

    // Highest-numbered accepted lane wins: XOR > AND > SUB > ADD.
    function automatic logic [3:0] winner(input logic [3:0] r);
        logic [3:0] w;
        w = 4'b0000;
        for (int i = 0; i < 4; i++) if (r[i]) w = 4'b0001 << i;
        return w;
    endfunction

    task automatic model_step();
        logic [3:0] new_st;
        logic       flip;
        if (rst) begin
            for (int j = 0; j < 16; j++) begin
                m_bh[j] = 4'b0000; m_sw[j] = 8'h00; m_dp[j] = 8'h00;
            end
            m_stable = 4'b0000; m_rise = 4'b0000; e_valid = 1'b0;
            e_op = 4'b0000; e_a = 4'b0000; e_b = 4'b0000; e_c = 4'b0000; e_d = 4'b0000;
        end else begin
            // A level accepted at the previous edge snapshots switches sampled two edges ago.
            if (m_rise != 4'b0000) begin
                e_op = winner(m_rise);
                e_a = bitrev(m_sw[1][3:0]); e_b = bitrev(m_sw[1][7:4]);
                e_c = bitrev(m_dp[1][3:0]); e_d = bitrev(m_dp[1][7:4]);
                e_valid = 1'b1;
            end else begin
                e_valid = 1'b0;
            end
            // A lane flips once its last D synchronised samples all disagree with it.
            new_st = m_stable;
            for (int b = 0; b < 4; b++) begin
                flip = 1'b1;
                for (int j = 1; j <= D; j++) if (m_bh[j][b] == m_stable[b]) flip = 1'b0;
                if (flip) new_st[b] = ~m_stable[b];
            end
            m_rise = new_st & ~m_stable;
            m_stable = new_st;
            for (int j = 15; j > 0; j--) begin
                m_bh[j] = m_bh[j-1]; m_sw[j] = m_sw[j-1]; m_dp[j] = m_dp[j-1];
            end
            m_bh[0] = {btn_0, btn_3, btn_1, btn_4};
            m_sw[0] = sw_pin;
            m_dp[0] = dip_pin;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(posedge clk);
        #2;
        if (op_valid) pulse_cnt++;
        n_checks++;
        if ({op_sel, opnd_a, opnd_b, opnd_c, opnd_d, op_valid, btn_state} !==
            {e_op, e_a, e_b, e_c, e_d, e_valid, m_stable}) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t: got op_sel=%b a=%h b=%h c=%h d=%h valid=%b btn=%b, expected op_sel=%b a=%h b=%h c=%h d=%h valid=%b btn=%b",
                     $time, op_sel, opnd_a, opnd_b, opnd_c, opnd_d, op_valid, btn_state,
                     e_op, e_a, e_b, e_c, e_d, e_valid, m_stable);
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    int p0;

    initial begin
        // 1: reset with random pins, then release with buttons low.
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sw_pin = 8'($urandom); dip_pin = 8'($urandom);
            {btn_0, btn_1, btn_3, btn_4} = 4'($urandom);
        end
        wait_edges(1);
        chk("rst_op_sel", op_sel, 4'b0000);
        chk("rst_opnd_a", opnd_a, 4'b0000);
        chk("rst_valid", {3'b000, op_valid}, 4'b0000);
        chk("rst_btn_state", btn_state, 4'b0000);
        {btn_0, btn_1, btn_3, btn_4} = 4'b0000;
        rst = 1'b0;
        p0 = pulse_cnt;
        wait_edges(20);
        chk_int("idle_pulses", pulse_cnt - p0, 0);
        chk("idle_op_sel", op_sel, 4'b0000);

        // 2: single ADD press, operand bit order.
        sw_pin = 8'b1100_1010; dip_pin = 8'h00;
        btn_4 = 1'b1;
        wait_edges(6);
        chk("add_early_valid", {3'b000, op_valid}, 4'b0000);
        wait_edges(1);
        chk("add_valid", {3'b000, op_valid}, 4'b0001);
        chk("add_op_sel", op_sel, 4'b0001);
        chk("add_opnd_a", opnd_a, 4'b0101);
        chk("add_opnd_b", opnd_b, 4'b0011);
        chk("add_opnd_c", opnd_c, 4'b0000);
        chk("model_pin_op", e_op, 4'b0001);
        chk("model_pin_a", e_a, 4'b0101);
        wait_edges(1);
        chk("add_valid_once", {3'b000, op_valid}, 4'b0000);
        btn_4 = 1'b0;
        wait_edges(10);

        // 3: bouncing SUB button, only the final held level counts.
        p0 = pulse_cnt;
        btn_1 = 1'b1; wait_edges(2);
        btn_1 = 1'b0; wait_edges(2);
        btn_1 = 1'b1; wait_edges(2);
        btn_1 = 1'b0; wait_edges(2);
        btn_1 = 1'b1;
        wait_edges(6);
        chk("sub_early_valid", {3'b000, op_valid}, 4'b0000);
        wait_edges(1);
        chk("sub_valid", {3'b000, op_valid}, 4'b0001);
        chk("sub_op_sel", op_sel, 4'b0010);
        wait_edges(5);
        chk_int("bounce_pulses", pulse_cnt - p0, 1);
        btn_1 = 1'b0;
        wait_edges(10);

        // 4: simultaneous XOR and ADD, then release both.
        sw_pin = 8'h3C; dip_pin = 8'hA5;
        btn_0 = 1'b1; btn_4 = 1'b1;
        p0 = pulse_cnt;
        wait_edges(7);
        chk("prio_valid", {3'b000, op_valid}, 4'b0001);
        chk("prio_op_sel", op_sel, 4'b1000);
        chk("prio_opnd_a", opnd_a, 4'b0011);
        chk("prio_opnd_b", opnd_b, 4'b1100);
        chk("prio_opnd_c", opnd_c, 4'b1010);
        chk("prio_opnd_d", opnd_d, 4'b0101);
        chk("prio_btn_state", btn_state, 4'b1001);
        wait_edges(3);
        btn_0 = 1'b0; btn_4 = 1'b0;
        wait_edges(12);
        chk_int("release_pulses", pulse_cnt - p0, 1);
        chk("release_op_sel", op_sel, 4'b1000);

        // 5: switch change is ignored until the next press; then last press wins.
        sw_pin = 8'hFF;
        wait_edges(8);
        chk("hold_opnd_a", opnd_a, 4'b0011);
        chk("hold_opnd_b", opnd_b, 4'b1100);
        btn_3 = 1'b1;
        wait_edges(7);
        chk("and_op_sel", op_sel, 4'b0100);
        chk("and_opnd_a", opnd_a, 4'b1111);
        chk("and_opnd_b", opnd_b, 4'b1111);
        chk("and_opnd_c", opnd_c, 4'b1010);
        wait_edges(3);
        btn_4 = 1'b1;
        wait_edges(7);
        chk("last_press_op_sel", op_sel, 4'b0001);
        btn_3 = 1'b0; btn_4 = 1'b0;
        wait_edges(12);

        // 6: reset mid-debounce with ADD held through release.
        btn_4 = 1'b1;
        wait_edges(3);
        rst = 1'b1;
        wait_edges(1);
        chk("midrst_op_sel", op_sel, 4'b0000);
        chk("midrst_opnd_a", opnd_a, 4'b0000);
        chk("midrst_btn_state", btn_state, 4'b0000);
        wait_edges(2);
        rst = 1'b0;
        wait_edges(6);
        chk("postrst_early_valid", {3'b000, op_valid}, 4'b0000);
        wait_edges(1);
        chk("postrst_valid", {3'b000, op_valid}, 4'b0001);
        chk("postrst_op_sel", op_sel, 4'b0001);
        chk("postrst_opnd_a", opnd_a, 4'b1111);
        btn_4 = 1'b0;
        wait_edges(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
